// File: rtl/spi_slave_bridge_if.sv
// Pin and local-bus bundle of the SPI slave bridge.
// slave = bridge side; master = SPI master and local register file side.
interface spi_slave_bridge_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 7
);
  logic              i_sclk;
  logic              i_mosi;
  logic              i_cs_n;
  logic              o_miso;
  logic              o_miso_oe;
  logic              o_wr_en;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_wdata;
  logic [DATA_W-1:0] i_rdata;
  logic              o_irq;
  logic              i_irq_clr;

  modport slave (
    input  i_sclk, i_mosi, i_cs_n, i_rdata, i_irq_clr,
    output o_miso, o_miso_oe, o_wr_en, o_rd_en, o_addr, o_wdata, o_irq
  );

  modport master (
    output i_sclk, i_mosi, i_cs_n, i_rdata, i_irq_clr,
    input  o_miso, o_miso_oe, o_wr_en, o_rd_en, o_addr, o_wdata, o_irq
  );
endinterface

// File: rtl/spi_slave_bridge.sv
// Mode-0 SPI slave: oversamples the SPI pins and turns command/address/data
// frames into single-cycle local read and write strobes.
module spi_slave_bridge #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               FCLK_CLK0,
  input logic               RST,
  spi_slave_bridge_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned FL_W  = $clog2(SYNC_STAGES + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD      = 3'd1;
  localparam logic [2:0] S_WR_DATA  = 3'd2;
  localparam logic [2:0] S_RD_FETCH = 3'd3;
  localparam logic [2:0] S_RD_DATA  = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_q, mosi_q, cs_q;
  logic                   sclk_d;
  logic [FL_W-1:0]        flush_cnt;
  logic                   armed;
  logic                   sclk_s, mosi_s, cs_s, sclk_rise, sclk_fall, flush_done;

  assign sclk_s     = sclk_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_q[SYNC_STAGES-1];
  assign cs_s       = cs_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign flush_done = (flush_cnt == FL_W'(SYNC_STAGES));

  // Synchronizers; 'armed' demands a genuinely observed high cs_n after reset
  // so a frame cut by reset cannot be mistaken for a new select.
  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      sclk_q    <= '0;
      mosi_q    <= '0;
      cs_q      <= '1;
      sclk_d    <= 1'b0;
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.i_sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.i_mosi};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], bus.i_cs_n};
      sclk_d <= sclk_s;
      if (!flush_done) flush_cnt <= flush_cnt + FL_W'(1);
      armed  <= armed | (flush_done & cs_s);
    end
  end

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-2:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d, rd_q, rd_d, miso_q, miso_d, oe_q, oe_d, irq_q, irq_d;

  always_ff @(posedge FCLK_CLK0) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      irq_q   <= irq_d;
    end
  end

  // Next-state and output logic; writes bump the address the cycle after the strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    addr_d  = wr_q ? addr_q + ADDR_W'(1) : addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    miso_d  = miso_q;
    oe_d    = ~cs_s;
    irq_d   = wr_q | (irq_q & ~bus.i_irq_clr);

    if (cs_s) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          miso_d = 1'b0;
          if (armed) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            rx_d = {rx_q[DATA_W-3:0], mosi_s};
            if (cnt_q == CNT_W'(7)) begin
              cnt_d  = '0;
              addr_d = ADDR_W'({rx_q[5:0], mosi_s});
              if (rx_q[6]) begin
                rd_d    = 1'b1;
                state_d = S_RD_FETCH;
              end else begin
                state_d = S_WR_DATA;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_WR_DATA: begin
          if (sclk_rise) begin
            rx_d = {rx_q[DATA_W-3:0], mosi_s};
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d   = '0;
              wdata_d = {rx_q, mosi_s};
              wr_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        // Read data arrives the cycle after the strobe is visible.
        S_RD_FETCH: begin
          if (!rd_q) begin
            tx_d    = bus.i_rdata[DATA_W-2:0];
            miso_d  = bus.i_rdata[DATA_W-1];
            state_d = S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          // The fall before the first rise of a word must not disturb its MSB.
          if (sclk_fall && cnt_q != '0) begin
            miso_d = tx_q[DATA_W-2];
            tx_d   = {tx_q[DATA_W-3:0], 1'b0};
          end
          if (sclk_rise) begin
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d   = '0;
              addr_d  = addr_q + ADDR_W'(1);
              rd_d    = 1'b1;
              state_d = S_RD_FETCH;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.o_miso    = miso_q;
  assign bus.o_miso_oe = oe_q;
  assign bus.o_wr_en   = wr_q;
  assign bus.o_rd_en   = rd_q;
  assign bus.o_addr    = addr_q;
  assign bus.o_wdata   = wdata_q;
  assign bus.o_irq     = irq_q;
endmodule

// File: tb/tb_spi_slave_bridge.sv
// Bench for spi_slave_bridge: bit-banged SPI master, local register model,
// and a strobe scoreboard fed by the stimulus and drained by a monitor.
module tb_spi_slave_bridge;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 7;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  spi_slave_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .FCLK_CLK0(clk),
    .RST      (rst),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  logic [38:0] exp_wr[$];
  logic [6:0]  exp_rd[$];
  logic [31:0] mem[128];
  logic        prev_strobe = 1'b0;
  logic [38:0] mon_wr;
  logic [6:0]  mon_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Local register file: one-cycle read latency.
  always @(posedge clk) begin
    if (rst) begin
      bus.i_rdata <= '0;
    end else begin
      if (bus.o_wr_en) mem[bus.o_addr] <= bus.o_wdata;
      if (bus.o_rd_en) bus.i_rdata <= mem[bus.o_addr];
    end
  end

  // Monitor: pops expected strobes as the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_wr_en || bus.o_rd_en)
        check("strobe_spacing", {62'd0, bus.o_wr_en & bus.o_rd_en, prev_strobe}, 64'd0);
      if (bus.o_wr_en) begin
        wr_count++;
        if (exp_wr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %h data %h, no write expected", bus.o_addr, bus.o_wdata);
        end else begin
          mon_wr = exp_wr.pop_front();
          check("wr_addr", 64'(bus.o_addr), 64'(mon_wr[38:32]));
          check("wr_data", 64'(bus.o_wdata), 64'(mon_wr[31:0]));
        end
      end
      if (bus.o_rd_en) begin
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_read: addr %h, no read expected", bus.o_addr);
        end else begin
          mon_rd = exp_rd.pop_front();
          check("rd_addr", 64'(bus.o_addr), 64'(mon_rd));
        end
      end
    end
    prev_strobe = bus.o_wr_en | bus.o_rd_en;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic cs_low;
    @(negedge clk);
    #2;
    bus.i_cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high;
    #HALF;
    bus.i_cs_n = 1'b1;
    #(4 * HALF);
  endtask

  task automatic spi_shift(input logic [31:0] tx, input int nbits, output logic [31:0] rx);
    rx = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.i_mosi = tx[i];
      #HALF;
      rx = {rx[30:0], bus.o_miso};
      bus.i_sclk = 1'b1;
      #HALF;
      bus.i_sclk = 1'b0;
    end
  endtask

  task automatic write_frame(input logic [6:0] addr, input logic [31:0] w0, input logic [31:0] w1,
                             input int n);
    logic [31:0] rx;
    exp_wr.push_back({addr, w0});
    if (n > 1) exp_wr.push_back({addr + 7'd1, w1});
    cs_low();
    spi_shift({25'd0, addr}, 8, rx);
    spi_shift(w0, 32, rx);
    if (n > 1) spi_shift(w1, 32, rx);
    cs_high();
  endtask

  task automatic read_frame(input logic [6:0] addr, output logic [31:0] data);
    logic [31:0] rx;
    exp_rd.push_back(addr);
    exp_rd.push_back(addr + 7'd1);
    cs_low();
    check("oe_selected", 64'(bus.o_miso_oe), 64'd1);
    check("miso_in_cmd", 64'(bus.o_miso), 64'd0);
    spi_shift({24'd0, 1'b1, addr}, 8, rx);
    spi_shift(32'd0, 32, data);
    cs_high();
    check("oe_deselected", 64'(bus.o_miso_oe), 64'd0);
    exp_rd.delete();
  endtask

  task automatic irq_watch;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_wr_en && n < 5000);
    if (!bus.o_wr_en) begin
      tests++;
      fails++;
      $display("FAIL irq_wait: no write strobe after %0d cycles, expected one", n);
    end else begin
      bus.i_irq_clr = 1'b1;
      @(negedge clk);
      check("irq_set_wins", 64'(bus.o_irq), 64'd1);
      @(negedge clk);
      check("irq_clear", 64'(bus.o_irq), 64'd0);
      bus.i_irq_clr = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rx;
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 32'(i);
    mem[3] = 32'h12345678;
    bus.i_sclk    = 1'b0;
    bus.i_mosi    = 1'b0;
    bus.i_cs_n    = 1'b1;
    bus.i_irq_clr = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_outputs",
          64'({bus.o_miso, bus.o_miso_oe, bus.o_wr_en, bus.o_rd_en, bus.o_addr, bus.o_wdata, bus.o_irq}),
          64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    write_frame(7'h05, 32'hDEADBEEF, 32'h0, 1);
    check("irq_after_write", 64'(bus.o_irq), 64'd1);

    read_frame(7'h03, rd);
    check("read_data", 64'(rd), 64'h12345678);

    write_frame(7'h7F, 32'h11111111, 32'h22222222, 2);
    check("mem_7f", 64'(mem[7'h7F]), 64'h11111111);
    check("mem_00", 64'(mem[7'h00]), 64'h22222222);

    n = wr_count;
    cs_low();
    spi_shift(32'h10, 8, rx);
    spi_shift(32'h000ABCDE, 20, rx);
    cs_high();
    check("abort_no_write", 64'(wr_count), 64'(n));
    write_frame(7'h11, 32'hA5A5A5A5, 32'h0, 1);

    @(negedge clk);
    bus.i_irq_clr = 1'b1;
    @(negedge clk);
    bus.i_irq_clr = 1'b0;
    check("irq_cleared_before", 64'(bus.o_irq), 64'd0);
    fork
      write_frame(7'h22, 32'h0F0F0F0F, 32'h0, 1);
      irq_watch();
    join

    exp_rd.push_back(7'h20);
    cs_low();
    spi_shift(32'hA0, 8, rx);
    spi_shift(32'h0, 4, rx);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset_mid_read",
          64'({bus.o_miso, bus.o_miso_oe, bus.o_wr_en, bus.o_rd_en, bus.o_addr, bus.o_wdata, bus.o_irq}),
          64'd0);
    rst = 1'b0;
    exp_rd.delete();
    n = wr_count;
    spi_shift(32'hFF, 8, rx);
    cs_high();
    check("aborted_frame_ignored", 64'(wr_count), 64'(n));
    write_frame(7'h30, 32'hCAFEF00D, 32'h0, 1);
    check("irq_after_reset_write", 64'(bus.o_irq), 64'd1);

    repeat (10) @(negedge clk);
    check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    check("wr_count_total", 64'(wr_count), 64'd6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
